// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states and
// the instruction classes produced by the opcode decoder.
package seq_pkg;

  // The datapath writes PC+1 into this register when link_wr_o accompanies reg_w_en_o.
  localparam logic [1:0] LINK_REG = 2'd3;

  localparam logic [3:0] OP_NOP = 4'b0000,
                         OP_ADD = 4'b0001,
                         OP_SUB = 4'b0010,
                         OP_AND = 4'b0011,
                         OP_OR  = 4'b0100,
                         OP_XOR = 4'b0101,
                         OP_SHL = 4'b0110,
                         OP_SHR = 4'b0111,
                         OP_J   = 4'b1000,
                         OP_JAL = 4'b1001,
                         OP_LW  = 4'b1010,
                         OP_SW  = 4'b1011,
                         OP_BEQ = 4'b1100,
                         OP_BNE = 4'b1101,
                         OP_LI  = 4'b1110,
                         OP_MOV = 4'b1111;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JUMP,
    CLS_JAL,
    CLS_BEQ,
    CLS_BNE,
    CLS_LOAD,
    CLS_STORE
  } instr_class_e;

endpackage

// File: rtl/seq_decode.sv
// Opcode classifier: maps the IR opcode nibble onto the control class the
// sequencer steps on. Anything not a control-flow or memory op is ALU.
module seq_decode
  import seq_pkg::*;
(
  input  logic [3:0]   opcode,
  output instr_class_e cls
);

  // purely combinational opcode-to-class lookup
  always_comb begin
    cls = CLS_ALU;
    case (opcode)
      OP_J:    cls = CLS_JUMP;
      OP_JAL:  cls = CLS_JAL;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_LW:   cls = CLS_LOAD;
      OP_SW:   cls = CLS_STORE;
      default: cls = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for the 8-bit core. Owns PC and IR, runs the
// FETCH/DECODE/EXEC/MEM/WB walk and gates the regfile/dmem strobes.
//
//  state  | meaning
//  HALT   | parked, halted_o high, waits for halt_i low
//  FETCH  | imem request outstanding (req low only for the first cycle after reset)
//  DECODE | IR classified, one cycle
//  EXEC   | jumps/branches retire here; JAL link write strobe is high
//  MEM    | dmem request held until ack; SW retires on ack
//  WB     | one-cycle regfile write, retire
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [7:0]       imem_rdata_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  input  logic [7:0]       rd0_data_i,
  input  logic             eq_i,
  output logic [7:0]       ir_o,
  output logic [PC_W-1:0]  pc_o,
  output logic             reg_w_en_o,
  output logic             link_wr_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             halted_o
);

  state_e          state;
  instr_class_e    cls;
  logic            retire_now;
  logic [PC_W-1:0] pc_next;

  seq_decode u_decode (
    .opcode (ir_o[7:4]),
    .cls    (cls)
  );

  assign imem_addr_o = pc_o;

  // identify the cycle an instruction completes and the PC it commits
  always_comb begin
    retire_now = 1'b0;
    pc_next    = pc_o + PC_W'(1);
    case (state)
      ST_EXEC: begin
        case (cls)
          CLS_JUMP, CLS_JAL: begin
            retire_now = 1'b1;
            pc_next    = PC_W'(rd0_data_i);
          end
          CLS_BEQ: begin
            retire_now = 1'b1;
            if (eq_i) pc_next = pc_o + PC_W'(2);
          end
          CLS_BNE: begin
            retire_now = 1'b1;
            if (!eq_i) pc_next = pc_o + PC_W'(2);
          end
          default: retire_now = 1'b0;
        endcase
      end
      ST_MEM:  retire_now = dmem_ack_i && (cls == CLS_STORE);
      ST_WB:   retire_now = 1'b1;
      default: retire_now = 1'b0;
    endcase
  end

  // state walk with registered request/strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FETCH;
      ir_o       <= '0;
      imem_req_o <= 1'b0;
      dmem_req_o <= 1'b0;
      dmem_we_o  <= 1'b0;
      reg_w_en_o <= 1'b0;
      link_wr_o  <= 1'b0;
      halted_o   <= 1'b0;
    end else begin
      reg_w_en_o <= 1'b0;
      link_wr_o  <= 1'b0;
      if (retire_now) begin
        // halt_i is only honoured on the way into FETCH
        dmem_req_o <= 1'b0;
        dmem_we_o  <= 1'b0;
        if (halt_i) begin
          state    <= ST_HALT;
          halted_o <= 1'b1;
        end else begin
          state      <= ST_FETCH;
          imem_req_o <= 1'b1;
        end
      end else begin
        case (state)
          ST_HALT: begin
            if (!halt_i) begin
              state      <= ST_FETCH;
              halted_o   <= 1'b0;
              imem_req_o <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (imem_req_o) begin
              if (imem_ack_i) begin
                ir_o       <= imem_rdata_i;
                imem_req_o <= 1'b0;
                state      <= ST_DECODE;
              end
            end else if (halt_i) begin
              state    <= ST_HALT;
              halted_o <= 1'b1;
            end else begin
              imem_req_o <= 1'b1;
            end
          end
          ST_DECODE: begin
            state <= ST_EXEC;
            // JAL writes its link during EXEC, so raise the strobe on entry
            if (cls == CLS_JAL) begin
              reg_w_en_o <= 1'b1;
              link_wr_o  <= 1'b1;
            end
          end
          ST_EXEC: begin
            if (cls == CLS_LOAD || cls == CLS_STORE) begin
              state      <= ST_MEM;
              dmem_req_o <= 1'b1;
              dmem_we_o  <= (cls == CLS_STORE);
            end else begin
              state      <= ST_WB;
              reg_w_en_o <= 1'b1;
            end
          end
          ST_MEM: begin
            // only loads reach here on ack; stores retire above
            if (dmem_ack_i) begin
              dmem_req_o <= 1'b0;
              dmem_we_o  <= 1'b0;
              state      <= ST_WB;
              reg_w_en_o <= 1'b1;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

  // PC commit, retire pulse and saturating retired-instruction count
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o         <= RESET_PC;
      retire_o     <= 1'b0;
      retire_cnt_o <= '0;
    end else begin
      retire_o <= retire_now;
      if (retire_now) begin
        pc_o <= pc_next;
        if (retire_cnt_o != '1) retire_cnt_o <= retire_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one task per scenario, hand-computed expectations.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_i;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_ack_i;
  logic [7:0]  imem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;
  logic [7:0]  rd0_data_i;
  logic        eq_i;
  logic [7:0]  ir_o;
  logic [7:0]  pc_o;
  logic        reg_w_en_o;
  logic        link_wr_o;
  logic        retire_o;
  logic [15:0] retire_cnt_o;
  logic        halted_o;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  instr_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .halt_i       (halt_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_ack_i   (dmem_ack_i),
    .rd0_data_i   (rd0_data_i),
    .eq_i         (eq_i),
    .ir_o         (ir_o),
    .pc_o         (pc_o),
    .reg_w_en_o   (reg_w_en_o),
    .link_wr_o    (link_wr_o),
    .retire_o     (retire_o),
    .retire_cnt_o (retire_cnt_o),
    .halted_o     (halted_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for a fetch request, then ack it with zero wait
  task automatic fetch(input logic [7:0] instr);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL fetch_req got=%b exp=1", imem_req_o); end
    imem_ack_i = 1'b1; imem_rdata_i = instr;
    tick();
    imem_ack_i = 1'b0;
  endtask

  // J through rd0 to place the PC; leaves the bench in the next FETCH cycle
  task automatic do_jump(input logic [7:0] target);
    fetch(8'h80);
    rd0_data_i = target;
    tick();
    tick();
    exp_cnt++;
    total++; if (pc_o !== target) begin bad++; $display("FAIL jump_pc got=%h exp=%h", pc_o, target); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (pc_o !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h exp=00", pc_o); end
    total++; if (ir_o !== 8'h00) begin bad++; $display("FAIL rst_ir got=%h exp=00", ir_o); end
    total++; if (retire_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", retire_cnt_o); end
    total++; if ({imem_req_o, dmem_req_o, reg_w_en_o, retire_o, halted_o} !== 5'b0) begin
      bad++; $display("FAIL rst_strobes got=%b exp=00000", {imem_req_o, dmem_req_o, reg_w_en_o, retire_o, halted_o}); end
    rst = 1'b0;
    tick();
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rst_req_after got=%b exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", imem_addr_o); end
  endtask

  task automatic test_alu();
    do_jump(8'h05);
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL alu_c1_wen got=%b exp=0", reg_w_en_o); end
    fetch(8'h1D);
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL alu_c2_wen got=%b exp=0", reg_w_en_o); end
    tick();
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL alu_c3_wen got=%b exp=0", reg_w_en_o); end
    tick();
    total++; if (reg_w_en_o !== 1'b1) begin bad++; $display("FAIL alu_c4_wen got=%b exp=1", reg_w_en_o); end
    total++; if (ir_o !== 8'h1D) begin bad++; $display("FAIL alu_ir got=%h exp=1D", ir_o); end
    total++; if (pc_o !== 8'h05) begin bad++; $display("FAIL alu_pc_wb got=%h exp=05", pc_o); end
    tick();
    exp_cnt++;
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL alu_c5_wen got=%b exp=0", reg_w_en_o); end
    total++; if (pc_o !== 8'h06) begin bad++; $display("FAIL alu_pc got=%h exp=06", pc_o); end
    total++; if (retire_o !== 1'b1) begin bad++; $display("FAIL alu_retire got=%b exp=1", retire_o); end
    total++; if (retire_cnt_o !== exp_cnt) begin bad++; $display("FAIL alu_cnt got=%0d exp=%0d", retire_cnt_o, exp_cnt); end
  endtask

  task automatic test_lw_wait();
    fetch(8'hAD);
    tick();
    total++; if (dmem_req_o !== 1'b0) begin bad++; $display("FAIL lw_exec_req got=%b exp=0", dmem_req_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if ({dmem_req_o, dmem_we_o, reg_w_en_o} !== 3'b100) begin
        bad++; $display("FAIL lw_mem_c%0d req/we/wen got=%b exp=100", i, {dmem_req_o, dmem_we_o, reg_w_en_o}); end
      if (i == 3) dmem_ack_i = 1'b1;
      tick();
      dmem_ack_i = 1'b0;
    end
    total++; if ({dmem_req_o, reg_w_en_o} !== 2'b01) begin
      bad++; $display("FAIL lw_wb req/wen got=%b exp=01", {dmem_req_o, reg_w_en_o}); end
    tick();
    exp_cnt++;
    total++; if (pc_o !== 8'h07) begin bad++; $display("FAIL lw_pc got=%h exp=07", pc_o); end
    total++; if (retire_cnt_o !== exp_cnt) begin bad++; $display("FAIL lw_cnt got=%0d exp=%0d", retire_cnt_o, exp_cnt); end
  endtask

  task automatic test_sw();
    fetch(8'hB0);
    tick();
    tick();
    total++; if ({dmem_req_o, dmem_we_o, reg_w_en_o} !== 3'b110) begin
      bad++; $display("FAIL sw_mem req/we/wen got=%b exp=110", {dmem_req_o, dmem_we_o, reg_w_en_o}); end
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    exp_cnt++;
    total++; if ({dmem_req_o, reg_w_en_o, retire_o} !== 3'b001) begin
      bad++; $display("FAIL sw_done req/wen/ret got=%b exp=001", {dmem_req_o, reg_w_en_o, retire_o}); end
    total++; if (pc_o !== 8'h08) begin bad++; $display("FAIL sw_pc got=%h exp=08", pc_o); end
  endtask

  // branch from current PC; checks no regfile write and the landing PC
  task automatic run_branch(input logic [7:0] instr, input logic eq, input logic [7:0] exp_pc);
    fetch(instr);
    eq_i = eq;
    tick();
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL br_%h_wen got=%b exp=0", instr, reg_w_en_o); end
    tick();
    exp_cnt++;
    total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL br_%h_eq%0b_pc got=%h exp=%h", instr, eq, pc_o, exp_pc); end
    total++; if (reg_w_en_o !== 1'b0 || retire_o !== 1'b1) begin
      bad++; $display("FAIL br_%h_ret wen/ret got=%b%b exp=01", instr, reg_w_en_o, retire_o); end
    eq_i = 1'b0;
  endtask

  task automatic test_branches();
    do_jump(8'hFE);
    run_branch(8'hCD, 1'b1, 8'h00);
    do_jump(8'hFE);
    run_branch(8'hCD, 1'b0, 8'hFF);
    run_branch(8'hD0, 1'b1, 8'h00);
    do_jump(8'hFF);
    run_branch(8'hD0, 1'b0, 8'h01);
    total++; if (retire_cnt_o !== exp_cnt) begin bad++; $display("FAIL br_cnt got=%0d exp=%0d", retire_cnt_o, exp_cnt); end
  endtask

  task automatic test_jal();
    do_jump(8'h10);
    fetch(8'h9D);
    rd0_data_i = 8'h40;
    total++; if (reg_w_en_o !== 1'b0) begin bad++; $display("FAIL jal_dec_wen got=%b exp=0", reg_w_en_o); end
    tick();
    total++; if ({reg_w_en_o, link_wr_o} !== 2'b11) begin
      bad++; $display("FAIL jal_exec wen/link got=%b exp=11", {reg_w_en_o, link_wr_o}); end
    total++; if (pc_o !== 8'h10) begin bad++; $display("FAIL jal_oldpc got=%h exp=10", pc_o); end
    tick();
    exp_cnt++;
    total++; if ({reg_w_en_o, link_wr_o} !== 2'b00) begin
      bad++; $display("FAIL jal_after wen/link got=%b exp=00", {reg_w_en_o, link_wr_o}); end
    total++; if (pc_o !== 8'h40) begin bad++; $display("FAIL jal_pc got=%h exp=40", pc_o); end
  endtask

  task automatic test_halt();
    fetch(8'h1D);
    tick();
    tick();
    halt_i = 1'b1;
    tick();
    exp_cnt++;
    total++; if ({halted_o, imem_req_o} !== 2'b10) begin
      bad++; $display("FAIL halt_enter halted/req got=%b exp=10", {halted_o, imem_req_o}); end
    total++; if (pc_o !== 8'h41) begin bad++; $display("FAIL halt_pc got=%h exp=41", pc_o); end
    imem_ack_i = 1'b1; imem_rdata_i = 8'h55;
    tick();
    imem_ack_i = 1'b0;
    tick();
    total++; if ({halted_o, imem_req_o} !== 2'b10) begin
      bad++; $display("FAIL halt_hold halted/req got=%b exp=10", {halted_o, imem_req_o}); end
    total++; if (ir_o !== 8'h1D) begin bad++; $display("FAIL halt_stray_ack ir got=%h exp=1D", ir_o); end
    halt_i = 1'b0;
    tick();
    total++; if ({halted_o, imem_req_o} !== 2'b01) begin
      bad++; $display("FAIL halt_exit halted/req got=%b exp=01", {halted_o, imem_req_o}); end
    total++; if (retire_cnt_o !== exp_cnt) begin bad++; $display("FAIL halt_cnt got=%0d exp=%0d", retire_cnt_o, exp_cnt); end
  endtask

  task automatic test_rst_in_mem();
    fetch(8'hA0);
    tick();
    tick();
    total++; if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL rmem_req got=%b exp=1", dmem_req_o); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 16'd0;
    total++; if ({dmem_req_o, imem_req_o, reg_w_en_o} !== 3'b000) begin
      bad++; $display("FAIL rmem_strobes got=%b exp=000", {dmem_req_o, imem_req_o, reg_w_en_o}); end
    total++; if (pc_o !== 8'h00) begin bad++; $display("FAIL rmem_pc got=%h exp=00", pc_o); end
    total++; if (retire_cnt_o !== exp_cnt) begin bad++; $display("FAIL rmem_cnt got=%0d exp=0", retire_cnt_o); end
    tick();
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rmem_refetch got=%b exp=1", imem_req_o); end
  endtask

  initial begin
    rst = 1'b1; halt_i = 1'b0; imem_ack_i = 1'b0; imem_rdata_i = 8'h00;
    dmem_ack_i = 1'b0; rd0_data_i = 8'h00; eq_i = 1'b0;
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw();
    test_branches();
    test_jal();
    test_halt();
    test_rst_in_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
